// File: rtl/nios2_gpio_pkg.sv
// Shared register addresses, edge encodings and readdata masking for the GPIO PIO.
package nios2_gpio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Ones in the low 'width' bits; keeps readdata above the GPIO width at zero.
  function automatic logic [31:0] rd_mask(input int width);
    logic [32:0] m;
    m = (33'd1 << width) - 33'd1;
    return m[31:0];
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser chain with delayed copy and warm-up gated edge pulses.
// Latency: pin to sync_in SYNC_STAGES cycles; edge_pulse feeds capture one cycle later.
// Backpressure: none, samples every cycle.
module gpio_sync_edge
  import nios2_gpio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  last_q;
  logic [WIDTH-1:0]                  raw_edge;
  logic [2:0]                        warm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      last_q   <= '0;
      warm_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      last_q <= sync_q[SYNC_STAGES-1];
      if (warm_cnt != WARM_DONE) warm_cnt <= warm_cnt + 3'd1;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  always_comb begin
    raw_edge = '0;
    case (EDGE_TYPE)
      EDGE_RISE: raw_edge = sync_in & ~last_q;
      EDGE_FALL: raw_edge = ~sync_in & last_q;
      default:   raw_edge = sync_in ^ last_q;
    endcase
  end

  // Chain and delayed copy both restart at zero, so the first samples after reset look like edges.
  assign edge_pulse = (warm_cnt == WARM_DONE) ? raw_edge : '0;

endmodule

// File: rtl/nios2_gpio_pio.sv
// Avalon-MM GPIO PIO: data/direction/mask/edge-capture registers, set/clear ports, level irq.
// Latency: writes zero wait states, readdata one cycle after the read strobe.
// Backpressure: none, every strobe is accepted on the edge it is seen.
module nios2_gpio_pio
  import nios2_gpio_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter logic [WIDTH-1:0] DATA_RESET  = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_view;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_val;
  logic             wr_en;
  logic             rd_en;
  logic             wd_unused;

  gpio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .sync_in   (sync_in),
    .edge_pulse(edge_pulse)
  );

  assign wr_en     = chipselect & ~write_n;
  assign rd_en     = chipselect & ~read_n & ~wr_en;
  assign wd        = writedata[WIDTH-1:0];
  assign wd_unused = ^writedata;
  assign data_view = (data_out & out_en) | (sync_in & ~out_en);
  assign cap_clr   = (wr_en && address == ADDR_EDGE_CAP) ? wd : '0;

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA:     rd_val = 32'(data_view);
      ADDR_DIR:      rd_val = 32'(out_en);
      ADDR_IRQ_MASK: rd_val = 32'(irq_mask);
      ADDR_EDGE_CAP: rd_val = 32'(edge_cap);
      default:       rd_val = '0;
    endcase
    rd_val = rd_val & rd_mask(WIDTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= DATA_RESET;
      out_en   <= DIR_RESET;
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= '0;
    end else begin
      // A fresh edge beats a simultaneous write-1 clear.
      edge_cap <= (edge_cap & ~cap_clr) | edge_pulse;
      if (wr_en) begin
        case (address)
          ADDR_DATA:     data_out <= wd;
          ADDR_DIR:      out_en   <= wd;
          ADDR_IRQ_MASK: irq_mask <= wd;
          ADDR_OUTSET:   data_out <= data_out | wd;
          ADDR_OUTCLR:   data_out <= data_out & ~wd;
          default:       ;
        endcase
      end
      if (rd_en) readdata <= rd_val;
    end
  end

  assign out_port = data_out;
  assign irq      = |(edge_cap & irq_mask);

endmodule

// File: doc/nios2_gpio_pio.md
Name: nios2_gpio_pio

Overview:
Parametrised general-purpose PIO, the successor to the fixed 10-bit output-only LED PIO. It is an Avalon-MM slave on the Nios II system interconnect with per-bit direction control and atomic set/clear of output bits. Input bits pass through a synchroniser, with per-bit edge capture and a maskable level interrupt to the Nios II IRQ input.

Parameters:
WIDTH, 10, number of GPIO bits (1..32).
DATA_RESET, 0, reset value of the output data register (WIDTH bits).
DIR_RESET, all ones, reset value of the direction register; 1 = output.
EDGE_TYPE, 0, edge that sets a capture bit: 0 rising, 1 falling, 2 any.
SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
read_n  in  1  active-low read strobe
writedata  in  32  write data
readdata  out  32  registered read data
in_port  in  WIDTH  asynchronous pin inputs
out_port  out  WIDTH  output data register
out_en  out  WIDTH  direction register; 1 = drive pin
irq  out  1  level interrupt

Behaviour:
- Reset is synchronous and active-high, sampled on rising clk. It sets:
  - data_out = DATA_RESET, out_en = DIR_RESET.
  - irq_mask = 0, edge_capture = 0, readdata = 0.
  - All synchroniser and edge flops = 0, and the warm-up counter is cleared.
- Register map (word addresses):
  - 0 DATA: write sets data_out = wd[WIDTH-1:0]. Read returns, per bit, data_out if out_en=1, otherwise the synchronised input.
  - 1 DIR: read/write.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: read returns the capture bits; a write-1 clears the corresponding bit.
  - 4 OUTSET: data_out |= wd. Reads as 0.
  - 5 OUTCLR: data_out &= ~wd. Reads as 0.
  - 6, 7: writes are ignored; reads return 0.
- A write is accepted on a clk edge when chipselect=1 and write_n=0. The register updates at that edge, with zero wait states.
- Reads: on a clk edge with chipselect=1 and read_n=0, readdata loads the addressed value as it was before that edge. Read latency is 1. readdata otherwise holds its value.
- If read and write are strobed together, the write executes and readdata holds.
- readdata[31:WIDTH] is always 0.
- Synchroniser: a change on in_port before edge k appears at the last sync stage after edge k+SYNC_STAGES-1.
- Edge detection compares the last sync stage with a one-cycle-delayed copy. The matching edge_capture bit sets at edge k+SYNC_STAGES.
- Edges are captured on all bits, including output-direction bits.
- Capture bits are sticky until cleared by a write-1 to EDGE_CAP.
- If a new edge and a write-1 clear hit the same bit in the same cycle, set wins and the bit stays 1.
- irq = |(edge_capture & irq_mask), combinational from registers. It asserts in the same cycle the capture bit sets and deasserts the cycle after the clear.
- Warm-up: after reset deasserts, a 3-bit counter suppresses capture for SYNC_STAGES+1 cycles. This prevents spurious edges from the synchroniser reset values.
- Reset asserted mid-operation overrides any concurrent write and restarts warm-up.
- Writes to DIR do not alter data_out. Changing a bit from output to input immediately switches the DATA read source for that bit.

Decomposition:
- Package nios2_gpio_pkg holds:
  - address constants ADDR_DATA..ADDR_OUTCLR;
  - EDGE_TYPE encodings EDGE_RISE, EDGE_FALL, EDGE_ANY;
  - a function that builds the readdata zero-extension mask.
- Sub-module gpio_sync_edge (WIDTH, SYNC_STAGES, EDGE_TYPE) contains the synchroniser chain, the delayed copy, warm-up gating and the edge-pulse output. The top level contains the registers, read mux and irq.

Test Plan:
1. Reset, then read every address. Expect:
   - DATA = 0x000 (inputs held 0);
   - DIR = 0x3FF, IRQ_MASK = 0, EDGE_CAP = 0;
   - addresses 4..7 read 0;
   - irq = 0 and out_port = 0.
2. Output path:
   - Write DATA = 0x155, then OUTSET = 0x00A, then OUTCLR = 0x101.
   - Expect out_port = 0x15F, then 0x05E. A DATA read returns 0x05E one cycle after read_n.
   - Write DATA = 0xFFFFF000; expect out_port = 0x000.
3. Input and edge capture (default rising):
   - DIR = 0x000, IRQ_MASK = 0x004; raise in_port[2] before edge k.
   - Expect EDGE_CAP bit 2 and irq at edge k+2. DATA read returns 0x004.
   - Lower the pin; expect no new capture.
4. Clear race: hold an edge on bit 2 so it captures in the same cycle as a write EDGE_CAP = 0x004. Expect the bit to stay 1 and irq to stay high. A later clear drops irq the next cycle.
5. Warm-up: hold in_port = 0x3FF through reset and release. Expect EDGE_CAP = 0 and irq = 0 after 10 cycles.
6. Reset mid-operation:
   - Assert reset during a write of DATA = 0x3FF with a capture pending. Expect all registers at reset values and irq = 0.
   - Repeat with WIDTH = 32, EDGE_TYPE = 2: in_port[31] toggled twice gives a capture bit set, and a read gives 0x80000000.
